// File: rtl/dpram_pkg.sv
// Shared types and helpers for the dual-port RAM family.
package dpram_pkg;

    // Result returned when a read and a write hit the same address on the same edge.
    typedef enum logic [0:0] {
        COLL_WRITE_FIRST = 1'b0,
        COLL_READ_FIRST  = 1'b1
    } coll_mode_e;

    // Deepest read pipeline the RAM wrappers support.
    localparam int MAX_READ_LATENCY = 2;

    // True when value is a non-zero power of two; such depths need no address range check.
    function automatic logic is_pow2(input int unsigned value);
        return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/sdpram_rd_pipe.sv
// Optional second read stage: registers data and valid, and is the output register
// when the RAM runs with two cycles of read latency.
module sdpram_rd_pipe #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] i_data,
    input  logic             i_valid,
    output logic [Width-1:0] o_data,
    output logic             o_valid
);

    logic [Width-1:0] data_r;
    logic             valid_r;

    // Second stage register; data only moves with a valid beat so it holds while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= i_valid;
            if (i_valid) begin
                data_r <= i_data;
            end
        end
    end

    assign o_data  = data_r;
    assign o_valid = valid_r;

endmodule

// File: rtl/sdpram_be.sv
// Single-clock simple dual-port RAM with byte-lane writes, a 1- or 2-cycle
// registered read path with valid strobe, and a selectable collision policy.
module sdpram_be
    import dpram_pkg::*;
#(
    parameter int         Depth         = 16,
    parameter int         Width         = 32,
    parameter int         ByteWidth     = 8,
    parameter int         ReadLatency   = 1,
    parameter coll_mode_e CollisionMode = COLL_WRITE_FIRST,
    localparam int        AddrWidth     = $clog2(Depth),
    localparam int        NumBytes      = Width / ByteWidth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [AddrWidth-1:0] i_wr_addr,
    input  logic [NumBytes-1:0]  i_wr_be,
    input  logic [Width-1:0]     i_wr_data,
    input  logic                 i_rd_en,
    input  logic [AddrWidth-1:0] i_rd_addr,
    output logic [Width-1:0]     o_rd_data,
    output logic                 o_rd_valid
);

    // Reject configurations the storage and pipeline cannot represent.
    if (Width % ByteWidth != 0) begin : g_bad_width
        $fatal(1, "sdpram_be: Width must be a multiple of ByteWidth");
    end
    if (ReadLatency < 1 || ReadLatency > MAX_READ_LATENCY) begin : g_bad_latency
        $fatal(1, "sdpram_be: ReadLatency must be 1 or 2");
    end
    if (Depth < 2) begin : g_bad_depth
        $fatal(1, "sdpram_be: Depth must be at least 2");
    end

    logic [Width-1:0] mem_r [Depth];

    logic             wr_in_range_s;
    logic             rd_in_range_s;
    logic             wr_ok_s;
    logic             rd_ok_s;
    logic             collision_s;
    logic [Width-1:0] rd_word_s;

    logic [Width-1:0] rd_data_r;
    logic             rd_valid_r;

    // A power-of-two depth covers every encodable address, so no compare is needed.
    if (is_pow2(Depth)) begin : g_full_range
        assign wr_in_range_s = 1'b1;
        assign rd_in_range_s = 1'b1;
    end else begin : g_partial_range
        localparam logic [AddrWidth:0] DepthW = (AddrWidth + 1)'(Depth);
        assign wr_in_range_s = ({1'b0, i_wr_addr} < DepthW);
        assign rd_in_range_s = ({1'b0, i_rd_addr} < DepthW);
    end

    // Reset blocks both ports; out-of-range writes are silently dropped.
    assign wr_ok_s     = i_wr_en & ~rst & wr_in_range_s;
    assign rd_ok_s     = i_rd_en & ~rst;
    assign collision_s = wr_ok_s & rd_ok_s & rd_in_range_s & (i_wr_addr == i_rd_addr);

    // Build the read word: stored word, merged with enabled write lanes on a write-first collision.
    always_comb begin
        rd_word_s = '0;
        if (rd_in_range_s) begin
            rd_word_s = mem_r[i_rd_addr];
            if (collision_s && (CollisionMode == COLL_WRITE_FIRST)) begin
                for (int k = 0; k < NumBytes; k++) begin
                    if (i_wr_be[k]) begin
                        rd_word_s[k*ByteWidth +: ByteWidth] = i_wr_data[k*ByteWidth +: ByteWidth];
                    end else begin
                        rd_word_s[k*ByteWidth +: ByteWidth] = mem_r[i_rd_addr][k*ByteWidth +: ByteWidth];
                    end
                end
            end else begin
                rd_word_s = mem_r[i_rd_addr];
            end
        end else begin
            rd_word_s = '0;
        end
    end

    // Byte-lane write into the array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            for (int k = 0; k < NumBytes; k++) begin
                if (i_wr_be[k]) begin
                    mem_r[i_wr_addr][k*ByteWidth +: ByteWidth] <= i_wr_data[k*ByteWidth +: ByteWidth];
                end
            end
        end
    end

    // First read stage: captures the read word and strobes valid once per accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_ok_s;
            if (rd_ok_s) begin
                rd_data_r <= rd_word_s;
            end
        end
    end

    if (ReadLatency == 2) begin : g_two_stage
        sdpram_rd_pipe #(
            .Width (Width)
        ) u_rd_pipe (
            .clk     (clk),
            .rst     (rst),
            .i_data  (rd_data_r),
            .i_valid (rd_valid_r),
            .o_data  (o_rd_data),
            .o_valid (o_rd_valid)
        );
    end else begin : g_one_stage
        assign o_rd_data  = rd_data_r;
        assign o_rd_valid = rd_valid_r;
    end

endmodule
